multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_ctrl_rv_decode.sv | 77 +++++++
 rtl/multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: ALU operation
// codes, opcode constants, FSM state encoding, instruction classes and the
// mux-select encodings driven towards the datapath.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SRL  = 4'b0011,
    ALU_SRA  = 4'b0100,
    ALU_AND  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SLT  = 4'b1011,
    ALU_SLTU = 4'b1100
  } alu_ops_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // FETCH is encoded as zero so the debug state output reads 0 in reset.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU_R, CL_ALU_I, CL_LUI, CL_AUIPC,
    CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR
  } iclass_t;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // 'alt' selects SUB/SRA; the caller only raises it where that is legal.
  function automatic alu_ops_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_ops_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_rv_decode.sv
// rv_decode: purely combinational instruction decoder.
//   ir           in  32  instruction register contents
//   iclass       out     instruction class (CL_NOP when illegal)
//   alu_op       out     ALU operation for the EXEC state
//   mem_size     out 2   load/store access size (funct3[1:0])
//   mem_unsigned out 1   zero-extend load (funct3[2])
//   funct3       out 3   raw funct3, used for branch condition selection
//   illegal      out 1   instruction is not a supported encoding
module rv_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output alu_ops_t    alu_op,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic [2:0]  funct3,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;

  assign opcode       = ir[6:0];
  assign funct3       = ir[14:12];
  assign funct7       = ir[31:25];
  assign mem_size     = ir[13:12];
  assign mem_unsigned = ir[14];

  always_comb begin
    iclass  = CL_NOP;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        iclass = CL_ALU_R;
        alu_op = alu_from_funct3(funct3, funct7[5]);
        // Only funct7=0 is legal, plus 0100000 for SUB and SRA.
        if (!((funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          illegal = 1'b1;
      end
      OPC_OPIMM: begin
        iclass = CL_ALU_I;
        // Immediate bit 30 selects SRAI only; for ADDI it is just immediate data.
        alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LUI:   iclass = CL_LUI;
      OPC_AUIPC: iclass = CL_AUIPC;
      OPC_JAL:   iclass = CL_JAL;
      OPC_JALR:  iclass = CL_JALR;
      OPC_LOAD: begin
        iclass = CL_LOAD;
        if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))
          illegal = 1'b1;
      end
      OPC_STORE: begin
        iclass = CL_STORE;
        if (funct3[2] || (funct3 == 3'b011))
          illegal = 1'b1;
      end
      OPC_BRANCH: begin
        iclass = CL_BRANCH;
        alu_op = ALU_SUB;
        if ((funct3 == 3'b010) || (funct3 == 3'b011))
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal word behaves as a NOP when it is not trapped.
    if (illegal) begin
      iclass = CL_NOP;
      alu_op = ALU_ADD;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM controller for a multicycle RV32I datapath.
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/imem_ack/instr_rdata   instruction fetch handshake
//   dmem_req/ack/we/size/unsigned   data memory handshake and access shape
//   ir_load, pc_write, pc_src       IR/old-PC capture and PC update control
//   alu_src_a/b, alu_op             ALU operand selects and operation
//   alu_zero/lt/ltu                 ALU compare flags used for branches
//   reg_write, wb_sel               register file write enable and source
//   state, illegal, timeout         debug state and one-cycle trap causes
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int TRAP_EN      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr_rdata,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        dmem_we,
  output logic [1:0]  dmem_size,
  output logic        dmem_unsigned,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output alu_ops_t    alu_op,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
);

  localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_SAT  = CW'(MEM_WAIT_MAX);
  // The trap decision is taken in the cycle whose increment would reach the
  // limit, so exactly MEM_WAIT_MAX request cycles are seen before TRAP.
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_WAIT_MAX > 0) && (TRAP_EN != 0);

  state_t        state_reg, state_next;
  logic [31:0]   ir_reg, ir_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          tcause_reg, tcause_next;  // 1: trap caused by timeout

  iclass_t       dec_class;
  alu_ops_t      dec_alu_op;
  logic [1:0]    dec_size;
  logic          dec_unsigned;
  logic [2:0]    dec_funct3;
  logic          dec_illegal;
  logic          branch_taken;
  logic          wait_hit;

  rv_decode u_decode (
    .ir           (ir_reg),
    .iclass       (dec_class),
    .alu_op       (dec_alu_op),
    .mem_size     (dec_size),
    .mem_unsigned (dec_unsigned),
    .funct3       (dec_funct3),
    .illegal      (dec_illegal)
  );

  assign state    = state_reg;
  assign ir_next  = ir_load ? instr_rdata : ir_reg;
  assign wait_hit = TIMEOUT_EN && (wait_cnt_reg == WAIT_LAST);

  always_comb begin
    case (dec_funct3)
      3'b000:  branch_taken = alu_zero;
      3'b001:  branch_taken = !alu_zero;
      3'b100:  branch_taken = alu_lt;
      3'b101:  branch_taken = !alu_lt;
      3'b110:  branch_taken = alu_ltu;
      3'b111:  branch_taken = !alu_ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  // Counting only while parked in FETCH/MEM; any transition clears it, which
  // also gives the required zero on entry. Saturates when traps are off.
  always_comb begin
    if ((state_next == state_reg) && ((state_reg == S_FETCH) || (state_reg == S_MEM)))
      wait_cnt_next = (wait_cnt_reg == WAIT_SAT) ? wait_cnt_reg : wait_cnt_reg + CW'(1);
    else
      wait_cnt_next = '0;
  end

  always_comb begin
    state_next    = state_reg;
    tcause_next   = tcause_reg;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_size     = DSIZE_BYTE;
    dmem_unsigned = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SEQ;
    alu_src_a     = SRC_A_RS1;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU;
    illegal       = 1'b0;
    timeout       = 1'b0;
    // Outputs stay quiet while reset is held, even though state already reads FETCH.
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load    = 1'b1;
            state_next = S_DECODE;
          end else if (wait_hit) begin
            state_next  = S_TRAP;
            tcause_next = 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_illegal && (TRAP_EN != 0)) begin
            state_next  = S_TRAP;
            tcause_next = 1'b0;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op     = dec_alu_op;
          state_next = S_WB;
          case (dec_class)
            CL_ALU_I: alu_src_b = SRC_B_IMM;
            CL_LUI: begin
              alu_src_a = SRC_A_ZERO;
              alu_src_b = SRC_B_IMM;
            end
            CL_AUIPC: begin
              alu_src_a = SRC_A_PC;
              alu_src_b = SRC_B_IMM;
            end
            CL_LOAD, CL_STORE: begin
              alu_src_b  = SRC_B_IMM;
              state_next = S_MEM;
            end
            CL_BRANCH: begin
              pc_write   = 1'b1;
              pc_src     = branch_taken ? PC_BRANCH : PC_SEQ;
              state_next = S_FETCH;
            end
            CL_JAL, CL_JALR: begin
              alu_src_b  = SRC_B_IMM;
              pc_write   = 1'b1;
              pc_src     = (dec_class == CL_JAL) ? PC_BRANCH : PC_JALR;
              reg_write  = 1'b1;
              wb_sel     = WB_PC4;
              state_next = S_FETCH;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req      = 1'b1;
          dmem_we       = (dec_class == CL_STORE);
          dmem_size     = dec_size;
          dmem_unsigned = (dec_class == CL_LOAD) && dec_unsigned;
          wb_sel        = (dec_class == CL_LOAD) ? WB_MEM : WB_ALU;
          if (dmem_ack) begin
            if (dec_class == CL_LOAD) begin
              state_next = S_WB;
            end else begin
              pc_write   = 1'b1;
              state_next = S_FETCH;
            end
          end else if (wait_hit) begin
            state_next  = S_TRAP;
            tcause_next = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = (dec_class != CL_NOP);
          wb_sel     = (dec_class == CL_LOAD) ? WB_MEM : WB_ALU;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end
        S_TRAP: begin
          pc_write   = 1'b1;
          pc_src     = PC_TRAP;
          illegal    = !tcause_reg;
          timeout    = tcause_reg;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      ir_reg       <= NOP_INSTR;
      wait_cnt_reg <= '0;
      tcause_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      wait_cnt_reg <= wait_cnt_next;
      tcause_reg   <= tcause_next;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The stimulus process pushes one
// expected output snapshot per clock cycle; the monitor pops and compares on
// the falling edge. A second instance with TRAP_EN=0 shares all inputs and is
// observed only for the untrapped-illegal case.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] dsize;
    logic       duns;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       timeout;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [1:0]  sa;
    logic [1:0]  sb;
    int          waits;
  } alu_vec_t;

  logic        clk, rst_n;
  logic        imem_ack, dmem_ack, alu_zero, alu_lt, alu_ltu;
  logic [31:0] instr_rdata;

  logic imem_req_a, ir_load_a, dmem_req_a, dmem_we_a, duns_a, pc_write_a;
  logic reg_write_a, illegal_a, timeout_a;
  logic [1:0] dsize_a, pc_src_a, src_a_a, src_b_a, wb_sel_a;
  logic [2:0] st_a;
  logic [3:0] alu_op_a;
  logic imem_req_n, ir_load_n, dmem_req_n, dmem_we_n, duns_n, pc_write_n;
  logic reg_write_n, illegal_n, timeout_n;
  logic [1:0] dsize_n, pc_src_n, src_a_n, src_b_n, wb_sel_n;
  logic [2:0] st_n;
  logic [3:0] alu_op_n;

  obs_t  obs_a, obs_n, obs;
  logic  use_nt;
  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  exp_cur;
  string tag_cur;
  int    checks, errors;

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .TRAP_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_a), .imem_ack(imem_ack), .instr_rdata(instr_rdata),
    .dmem_req(dmem_req_a), .dmem_ack(dmem_ack), .dmem_we(dmem_we_a),
    .dmem_size(dsize_a), .dmem_unsigned(duns_a),
    .ir_load(ir_load_a), .pc_write(pc_write_a), .pc_src(pc_src_a),
    .alu_src_a(src_a_a), .alu_src_b(src_b_a), .alu_op(alu_op_a),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .reg_write(reg_write_a), .wb_sel(wb_sel_a), .state(st_a),
    .illegal(illegal_a), .timeout(timeout_a)
  );

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .TRAP_EN(0)) u_dut_nt (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_n), .imem_ack(imem_ack), .instr_rdata(instr_rdata),
    .dmem_req(dmem_req_n), .dmem_ack(dmem_ack), .dmem_we(dmem_we_n),
    .dmem_size(dsize_n), .dmem_unsigned(duns_n),
    .ir_load(ir_load_n), .pc_write(pc_write_n), .pc_src(pc_src_n),
    .alu_src_a(src_a_n), .alu_src_b(src_b_n), .alu_op(alu_op_n),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .reg_write(reg_write_n), .wb_sel(wb_sel_n), .state(st_n),
    .illegal(illegal_n), .timeout(timeout_n)
  );

  assign obs_a = {st_a, imem_req_a, ir_load_a, dmem_req_a, dmem_we_a, dsize_a, duns_a,
                  pc_write_a, pc_src_a, src_a_a, src_b_a, alu_op_a, reg_write_a,
                  wb_sel_a, illegal_a, timeout_a};
  assign obs_n = {st_n, imem_req_n, ir_load_n, dmem_req_n, dmem_we_n, dsize_n, duns_n,
                  pc_write_n, pc_src_n, src_a_n, src_b_n, alu_op_n, reg_write_n,
                  wb_sel_n, illegal_n, timeout_n};
  assign obs = use_nt ? obs_n : obs_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
      tag_cur = tag_q.pop_front();
      checks++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL %s got=%h exp=%h (st got %0d exp %0d)",
                 tag_cur, obs, exp_cur, obs.st, exp_cur.st);
      end
    end
  end

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.imem_req = (st == S_FETCH);
    return e;
  endfunction

  // Called at posedge+1 with this cycle's inputs already applied.
  task automatic step(input obs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step('0, "reset0");
    step('0, "reset1");
    checks++;
    if ((obs_a !== '0) || (st_a !== S_FETCH) || (imem_req_a !== 1'b0) || (dmem_req_a !== 1'b0)) begin
      errors++;
      $display("FAIL reset_state got=%h st=%0d imem_req=%b dmem_req=%b",
               obs_a, st_a, imem_req_a, dmem_req_a);
    end else begin
      $display("PASS reset_state st=%0d", st_a);
    end
    rst_n = 1'b1;
  endtask

  // Ignored dmem_ack is driven during the wait cycles on purpose.
  task automatic do_fetch(input logic [31:0] instr, input int waits, input string t);
    obs_t e;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b1;
      step(mk(S_FETCH), {t, "_fwait"});
    end
    dmem_ack    = 1'b0;
    imem_ack    = 1'b1;
    instr_rdata = instr;
    e = mk(S_FETCH);
    e.ir_load = 1'b1;
    step(e, {t, "_fack"});
    imem_ack = 1'b0;
  endtask

  // A stray imem_ack carrying an illegal word must not reload the IR.
  task automatic do_decode(input string t);
    imem_ack    = 1'b1;
    instr_rdata = 32'h0000_007F;
    step(mk(S_DECODE), {t, "_dec"});
    imem_ack = 1'b0;
  endtask

  alu_vec_t av[7];
  obs_t     e;

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr_rdata = '0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; use_nt = 1'b0;
    checks = 0; errors = 0;

    av[0] = '{32'h0050_0093, ALU_ADD,  SRC_A_RS1,  SRC_B_IMM, 2};  // addi x1,x0,5
    av[1] = '{32'h4020_81B3, ALU_SUB,  SRC_A_RS1,  SRC_B_RS2, 0};  // sub
    av[2] = '{32'h0020_A1B3, ALU_SLT,  SRC_A_RS1,  SRC_B_RS2, 1};  // slt
    av[3] = '{32'h0020_B1B3, ALU_SLTU, SRC_A_RS1,  SRC_B_RS2, 0};  // sltu
    av[4] = '{32'h4020_D193, ALU_SRA,  SRC_A_RS1,  SRC_B_IMM, 0};  // srai
    av[5] = '{32'h1234_50B7, ALU_ADD,  SRC_A_ZERO, SRC_B_IMM, 0};  // lui
    av[6] = '{32'h0000_1097, ALU_ADD,  SRC_A_PC,   SRC_B_IMM, 1};  // auipc

    @(posedge clk); #1;
    do_reset();

    // ALU-class instructions: FETCH / DECODE / EXEC / WB.
    foreach (av[i]) begin
      do_fetch(av[i].instr, av[i].waits, "alu");
      do_decode("alu");
      e = mk(S_EXEC);
      e.alu_op = av[i].op; e.src_a = av[i].sa; e.src_b = av[i].sb;
      step(e, "alu_exec");
      e = mk(S_WB);
      e.reg_write = 1'b1; e.pc_write = 1'b1; e.wb_sel = WB_ALU; e.pc_src = PC_SEQ;
      step(e, "alu_wb");
    end

    // Branches: {instr, zero, ltu, taken}.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] bi;
      logic        bz, bu, tk;
      case (i)
        0: begin bi = 32'h0020_8463; bz = 1'b1; bu = 1'b0; tk = 1'b1; end  // beq taken
        1: begin bi = 32'h0020_8463; bz = 1'b0; bu = 1'b0; tk = 1'b0; end  // beq not
        2: begin bi = 32'h0020_9463; bz = 1'b0; bu = 1'b0; tk = 1'b1; end  // bne taken
        3: begin bi = 32'h0020_F463; bz = 1'b0; bu = 1'b0; tk = 1'b1; end  // bgeu taken
        default: begin bi = 32'h0020_F463; bz = 1'b0; bu = 1'b1; tk = 1'b0; end  // bgeu not
      endcase
      do_fetch(bi, 0, "br");
      do_decode("br");
      alu_zero = bz; alu_ltu = bu;
      e = mk(S_EXEC);
      e.alu_op = ALU_SUB; e.pc_write = 1'b1; e.pc_src = tk ? PC_BRANCH : PC_SEQ;
      step(e, "br_exec");
      alu_zero = 1'b0; alu_ltu = 1'b0;
    end

    // lbu x5,0(x1): ack on the 4th MEM cycle.
    do_fetch(32'h0000_C283, 0, "lbu");
    do_decode("lbu");
    e = mk(S_EXEC); e.src_b = SRC_B_IMM;
    step(e, "lbu_exec");
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      e = mk(S_MEM);
      e.dmem_req = 1'b1; e.dsize = DSIZE_BYTE; e.duns = 1'b1; e.wb_sel = WB_MEM;
      step(e, "lbu_mem");
    end
    dmem_ack = 1'b0;
    e = mk(S_WB); e.reg_write = 1'b1; e.wb_sel = WB_MEM; e.pc_write = 1'b1;
    step(e, "lbu_wb");

    // Illegal encodings trap straight from DECODE.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ii;
      case (i)
        0: ii = 32'h0000_007F;        // unknown opcode
        1: ii = 32'h0000_B283;        // load funct3 011
        2: ii = 32'h0020_A463;        // branch funct3 010
        default: ii = 32'h0420_81B3;  // R-type funct7 0000010
      endcase
      do_fetch(ii, 1, "ill");
      do_decode("ill");
      e = mk(S_TRAP); e.pc_write = 1'b1; e.pc_src = PC_TRAP; e.illegal = 1'b1;
      step(e, "ill_trap");
    end

    // TRAP_EN=0 instance: illegal word runs as a NOP, no register write.
    do_reset();
    use_nt = 1'b1;
    do_fetch(32'h0000_007F, 0, "nt");
    do_decode("nt");
    step(mk(S_EXEC), "nt_exec");
    e = mk(S_WB); e.pc_write = 1'b1;
    step(e, "nt_wb");
    step(mk(S_FETCH), "nt_fetch");
    use_nt = 1'b0;
    do_reset();

    // sw with no ack: 15 MEM cycles then a timeout trap; then ack on cycle 15.
    for (int pass = 0; pass < 2; pass++) begin
      do_fetch(32'h0020_A023, 0, "sw");
      do_decode("sw");
      e = mk(S_EXEC); e.src_b = SRC_B_IMM;
      step(e, "sw_exec");
      for (int i = 1; i <= 15; i++) begin
        dmem_ack = (pass == 1) && (i == 15);
        e = mk(S_MEM);
        e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.dsize = DSIZE_WORD;
        if (dmem_ack) e.pc_write = 1'b1;
        step(e, "sw_mem");
      end
      dmem_ack = 1'b0;
      if (pass == 0) begin
        checks++;
        if ((st_a !== S_TRAP) || (timeout_a !== 1'b1) || (pc_src_a !== PC_TRAP) ||
            (pc_write_a !== 1'b1)) begin
          errors++;
          $display("FAIL wait_expired st=%0d timeout=%b pc_src=%b pc_write=%b",
                   st_a, timeout_a, pc_src_a, pc_write_a);
        end else begin
          $display("PASS wait_expired st=%0d timeout=%b", st_a, timeout_a);
        end
        e = mk(S_TRAP); e.pc_write = 1'b1; e.pc_src = PC_TRAP; e.timeout = 1'b1;
        step(e, "sw_timeout");
      end
    end

    // Reset asserted between clock edges while in MEM.
    do_fetch(32'h0000_C283, 0, "rst");
    do_decode("rst");
    e = mk(S_EXEC); e.src_b = SRC_B_IMM;
    step(e, "rst_exec");
    e = mk(S_MEM); e.dmem_req = 1'b1; e.duns = 1'b1; e.wb_sel = WB_MEM;
    step(e, "rst_mem");
    rst_n = 1'b0;
    step('0, "rst_midmem");
    step('0, "rst_hold");
    rst_n = 1'b1;
    do_fetch(32'h0050_0093, 0, "post");
    do_decode("post");
    e = mk(S_EXEC); e.src_b = SRC_B_IMM;
    step(e, "post_exec");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
